// File: rtl/div_seq_fl.sv
// Sequential restoring floating-point divider, one quotient bit per cycle.
// Optional divide-by-zero detection is enabled with `define FL_DIV_BYZERO_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start_i; out_o holds the last result
// S_LOAD | latch mantissas, result sign and exponent difference
// S_CALC | restoring iteration, NBMANT+1 quotient bits MSB first
// S_NORM | normalize, range-check, register out_o and pulse done_o
module div_seq_fl #(
    parameter int NBMANT = 22,
    parameter int NBEXPO = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [NBMANT+NBEXPO:0] a_i,
    input  logic [NBMANT+NBEXPO:0] b_i,
    output logic [NBMANT+NBEXPO:0] out_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   dz_o
);

    localparam int W  = NBMANT + NBEXPO + 1;
    localparam int EW = NBEXPO + 2;
    localparam int CW = $clog2(NBMANT + 1);

    localparam logic [W-1:0]        ZERO_W  = {1'b0, 1'b1, {(NBEXPO-1){1'b0}}, {NBMANT{1'b0}}};
    localparam logic [NBEXPO-1:0]   EXP_MAX = {1'b0, {(NBEXPO-1){1'b1}}};
    localparam logic signed [EW-1:0] E_MAX  = EW'(2**(NBEXPO-1) - 1);
    localparam logic signed [EW-1:0] E_MIN  = EW'(-(2**(NBEXPO-1)));
    localparam logic signed [EW-1:0] ADJ_HI = EW'(NBMANT - 1);
    localparam logic signed [EW-1:0] ADJ_LO = EW'(NBMANT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_NORM
    } state_t;

    state_t                 state_q, state_d;
    logic [NBMANT-1:0]      mb_q, mb_d;
    logic [NBMANT:0]        r_q, r_d;
    logic [NBMANT:0]        q_q, q_d;
    logic                   sign_q, sign_d;
    logic                   ma_zero_q, ma_zero_d;
    logic signed [EW-1:0]   ediff_q, ediff_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [NBMANT-1:0]      a_man, b_man;
    logic [NBEXPO-1:0]      a_exp, b_exp;
    logic                   qbit;
    logic [NBMANT:0]        r_sub;
    logic signed [EW-1:0]   e_norm;
    logic [NBMANT-1:0]      m_norm;
    logic [W-1:0]           result;
    logic                   byz;

    assign a_man = a_i[NBMANT-1:0];
    assign b_man = b_i[NBMANT-1:0];
    assign a_exp = a_i[W-2:NBMANT];
    assign b_exp = b_i[W-2:NBMANT];

    assign qbit  = (r_q >= {1'b0, mb_q});
    assign r_sub = qbit ? (r_q - {1'b0, mb_q}) : r_q;

    assign m_norm = q_q[NBMANT] ? q_q[NBMANT:1] : q_q[NBMANT-1:0];
    assign e_norm = q_q[NBMANT] ? (ediff_q - ADJ_HI) : (ediff_q - ADJ_LO);

`ifdef FL_DIV_BYZERO_EN
    logic byz_q;
    logic dz_q;

    // Divisor-zero flag is captured at LOAD so b_i may change afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byz_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                byz_q <= (b_man == '0);
            end
            if (state_q == S_IDLE && start_i) begin
                dz_q <= 1'b0;
            end else if (state_q == S_NORM) begin
                dz_q <= byz_q;
            end
        end
    end

    assign byz  = byz_q;
    assign dz_o = dz_q;
`else
    assign byz  = 1'b0;
    assign dz_o = 1'b0;
`endif

    always_comb begin
        result = {sign_q, e_norm[NBEXPO-1:0], m_norm};
        if (byz) begin
            result = {sign_q, EXP_MAX, {NBMANT{1'b1}}};
        end else if (ma_zero_q || m_norm == '0) begin
            result = ZERO_W;
        end else if (e_norm > E_MAX) begin
            result = {sign_q, EXP_MAX, {NBMANT{1'b1}}};
        end else if (e_norm < E_MIN) begin
            result = ZERO_W;
        end
    end

    always_comb begin
        state_d   = state_q;
        mb_d      = mb_q;
        r_d       = r_q;
        q_d       = q_q;
        sign_d    = sign_q;
        ma_zero_d = ma_zero_q;
        ediff_d   = ediff_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                mb_d      = b_man;
                r_d       = {1'b0, a_man};
                q_d       = '0;
                sign_d    = a_i[W-1] ^ b_i[W-1];
                ma_zero_d = (a_man == '0);
                ediff_d   = $signed({{2{a_exp[NBEXPO-1]}}, a_exp})
                          - $signed({{2{b_exp[NBEXPO-1]}}, b_exp});
                cnt_d     = CW'(NBMANT);
                state_d   = S_CALC;
            end
            S_CALC: begin
                r_d = {r_sub[NBMANT-1:0], 1'b0};
                q_d = {q_q[NBMANT-1:0], qbit};
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_NORM: begin
                out_d   = result;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mb_q      <= '0;
            r_q       <= '0;
            q_q       <= '0;
            sign_q    <= 1'b0;
            ma_zero_q <= 1'b0;
            ediff_q   <= '0;
            cnt_q     <= '0;
            out_q     <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mb_q      <= mb_d;
            r_q       <= r_d;
            q_q       <= q_d;
            sign_q    <= sign_d;
            ma_zero_q <= ma_zero_d;
            ediff_q   <= ediff_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_div_seq_fl.sv
// Self-checking bench for div_seq_fl: directed vectors, random operands against
// an arithmetic quotient model, busy/back-to-back timing and mid-run reset.
module tb_div_seq_fl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [28:0] a, b;
    logic [28:0] out;
    logic        busy, done, dz;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [28:0] ZERO_W = 29'h0800_0000;

    div_seq_fl dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .out_o   (out),
        .busy_o  (busy),
        .done_o  (done),
        .dz_o    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [28:0] mk(input logic s, input int e, input int m);
        return {s, 6'(e), 22'(m)};
    endfunction

    // Quotient computed by integer division of the scaled mantissas.
    function automatic void ref_div(input logic [28:0] av, input logic [28:0] bv,
                                    output logic [28:0] r, output logic d);
        logic s;
        int ea, eb, e;
        longint unsigned ma, mb, q, m;
        s  = av[28] ^ bv[28];
        ea = int'($signed(av[27:22]));
        eb = int'($signed(bv[27:22]));
        ma = 64'(av[21:0]);
        mb = 64'(bv[21:0]);
        d  = 1'b0;
`ifdef FL_DIV_BYZERO_EN
        if (mb == 0) begin
            r = mk(s, 31, 22'h3FFFFF);
            d = 1'b1;
            return;
        end
`endif
        if (ma == 0) begin
            r = ZERO_W;
            return;
        end
        if (mb == 0) q = 64'h7F_FFFF;
        else         q = (ma << 22) / mb;
        if (q >= 64'h40_0000) begin
            m = q >> 1;
            e = ea - eb - 21;
        end else begin
            m = q;
            e = ea - eb - 22;
        end
        if (m == 0)       r = ZERO_W;
        else if (e > 31)  r = mk(s, 31, 22'h3FFFFF);
        else if (e < -32) r = ZERO_W;
        else              r = {s, 6'(e), 22'(m)};
    endfunction

    // One division: start for one cycle, operands scrambled right after LOAD.
    task automatic do_div(input logic [28:0] av, input logic [28:0] bv,
                          output logic [28:0] res, output logic dzv, output int lat);
        res = 'x;
        dzv = 1'bx;
        lat = -1;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || dz !== 1'b0)
            $display("FAIL accept_flags: busy=%b done=%b dz=%b want 1 0 0", busy, done, dz);
        else pass_cnt++;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                a = 29'($urandom);
                b = 29'($urandom);
            end
            if (done) begin
                lat = n;
                res = out;
                dzv = dz;
                break;
            end
        end
        total++;
        if (busy !== 1'b0) $display("FAIL busy_at_done: got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out !== ZERO_W || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0)
            $display("FAIL reset_vals: out=%h busy=%b done=%b dz=%b want %h 0 0 0",
                     out, busy, done, dz, ZERO_W);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_reset_idle: busy=%b done=%b", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_directed;
        logic [28:0] av[5], bv[5], ev[5], res;
        logic        ed[5], dzv;
        int          lat;
        av[0] = mk(0, -19, 22'h300000); bv[0] = mk(0, -20, 22'h200000); ev[0] = mk(0, -20, 22'h300000);
        av[1] = mk(0, -21, 22'h200000); bv[1] = mk(1, -20, 22'h300000); ev[1] = mk(1, -23, 22'h2AAAAA);
        av[2] = mk(0,  31, 22'h200000); bv[2] = mk(0, -31, 22'h3FFFFF); ev[2] = mk(0,  31, 22'h3FFFFF);
        av[3] = mk(0, -32, 22'h200000); bv[3] = mk(0,  31, 22'h200000); ev[3] = mk(0, -32, 0);
        av[4] = mk(0, -19, 22'h280000); bv[4] = mk(0, -32, 0);
`ifdef FL_DIV_BYZERO_EN
        ev[4] = mk(0, 31, 22'h3FFFFF); ed[4] = 1'b1;
`else
        ev[4] = mk(0, -8, 22'h3FFFFF); ed[4] = 1'b0;
`endif
        for (int i = 0; i < 4; i++) ed[i] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_div(av[i], bv[i], res, dzv, lat);
            total++;
            if (lat !== 25) $display("FAIL dir%0d_latency: got %0d want 25", i, lat);
            else pass_cnt++;
            total++;
            if (res !== ev[i] || dzv !== ed[i])
                $display("FAIL dir%0d_result: got %h dz=%b want %h dz=%b", i, res, dzv, ev[i], ed[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        logic [28:0] av, bv, res, exp_r;
        logic        dzv, exp_d;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            av = {1'($urandom), 6'($urandom), 22'($urandom) | 22'h200000};
            bv = {1'($urandom), 6'($urandom), 22'($urandom) | 22'h200000};
            if (i % 10 == 3) av[21:0] = '0;
            if (i % 10 == 7) bv[21:0] = '0;
            ref_div(av, bv, exp_r, exp_d);
            do_div(av, bv, res, dzv, lat);
            total++;
            if (lat !== 25 || res !== exp_r || dzv !== exp_d)
                $display("FAIL rand%0d: a=%h b=%h got %h dz=%b lat=%0d want %h dz=%b lat=25",
                         i, av, bv, res, dzv, lat, exp_r, exp_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore;
        logic [28:0] av, bv, exp_r;
        logic        exp_d;
        int          dones, first;
        av = {1'($urandom), 6'($urandom), 22'($urandom) | 22'h200000};
        bv = {1'($urandom), 6'($urandom), 22'($urandom) | 22'h200000};
        ref_div(av, bv, exp_r, exp_d);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = (n == 9);
            if (n == 1) a = 29'($urandom);
            if (done) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    total++;
                    if (out !== exp_r) $display("FAIL busy_ignore_result: got %h want %h", out, exp_r);
                    else pass_cnt++;
                end
            end
        end
        start = 1'b0;
        total++;
        if (dones !== 1 || first !== 25)
            $display("FAIL busy_ignore_dones: got %0d at %0d want 1 at 25", dones, first);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [28:0] res, exp_r;
        logic        dzv, exp_d;
        int          lat;
        do_div(mk(1, 5, 22'h3ABCDE), mk(0, 2, 22'h2468AC), res, dzv, lat);
        ref_div(mk(1, 5, 22'h3ABCDE), mk(0, 2, 22'h2468AC), exp_r, exp_d);
        total++;
        if (lat !== 25 || res !== exp_r)
            $display("FAIL b2b_first: got %h lat=%0d want %h lat=25", res, lat, exp_r);
        else pass_cnt++;
        // Starting in the done cycle: accepted one edge later, done 26 after the first.
        do_div(mk(0, -19, 22'h300000), mk(0, -20, 22'h200000), res, dzv, lat);
        total++;
        if (lat + 1 !== 26 || res !== mk(0, -20, 22'h300000))
            $display("FAIL b2b_second: got %h gap=%0d want %h gap=26", res, lat + 1, mk(0, -20, 22'h300000));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [28:0] res;
        logic        dzv;
        int          lat, dones;
        a = mk(0, -21, 22'h200000);
        b = mk(1, -20, 22'h300000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out !== ZERO_W || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_vals: out=%h busy=%b done=%b want %h 0 0", out, busy, done, ZERO_W);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) $display("FAIL reset_mid_no_done: got %0d active cycles want 0", dones);
        else pass_cnt++;
        do_div(mk(0, -21, 22'h200000), mk(1, -20, 22'h300000), res, dzv, lat);
        total++;
        if (lat !== 25 || res !== mk(1, -23, 22'h2AAAAA))
            $display("FAIL reset_mid_fresh: got %h lat=%0d want %h lat=25", res, lat, mk(1, -23, 22'h2AAAAA));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
